saturate_shift: RTL and testbench
=================================

Name: saturate_shift

Overview:
- Streaming requantiser: arithmetic right shift of CHAN packed signed lanes, then saturation from ARGW to RESW bits.
- Successor to the single-lane fixed-width saturate stage, with a runtime shift, multi-lane support and a sticky saturation counter.
- Sits between accumulator outputs and the activation/memory write path.
- Two-stage valid/ready pipeline with full throughput.

Parameters:
- ARGW, 24, signed input lane width.
- RESW, 16, signed output lane width; must satisfy RESW <= ARGW.
- CHAN, 1, number of lanes packed per beat; lane i occupies bits [i*W +: W].
- SHIFTW, 5, width of the shift input.
- CNTW, 16, width of the saturation counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- shift  in  SHIFTW  right-shift amount; sampled together with arg_data on the arg handshake
- arg_valid  in  1  input beat valid
- arg_data  in  CHAN*ARGW  packed signed input lanes
- arg_ready  out  1  input accepted when arg_valid & arg_ready
- res_valid  out  1  output beat valid
- res_data  out  CHAN*RESW  packed signed results
- res_ready  in  1  downstream ready
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  CNTW  number of output beats with at least one clamped lane

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - res_valid=0, res_data=0, sat_count=0.
  - Both stages are empty, so arg_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded; no partial beat is ever presented.
- Pipeline: S1 registers the shifted value (ARGW+1 bits per lane); S2 registers the saturated result and a per-beat clamp flag.
- Latency: 2 cycles from arg handshake to res_valid when res_ready stays high. Throughput is 1 beat per cycle.
- Handshake rules:
  - S2 loads when S2 is empty or res_ready=1.
  - S1 advances when S2 loads.
  - arg_ready = !s1_valid | s2_load (combinational from res_ready is allowed).
  - res_data and res_valid hold stable while res_valid & !res_ready.
  - No beat is dropped or duplicated under any ready pattern.
- Shift:
  - Effective shift e = min(shift, ARGW).
  - Truncating arithmetic shift: floor(x / 2^e).
  - e=0 passes the value through.
  - e=ARGW yields 0 for x>=0 and -1 for x<0.
- Saturation per lane:
  - If v > 2^(RESW-1)-1, output 0x7f..f.
  - If v < -2^(RESW-1), output 0x80..0.
  - Otherwise output the low RESW bits of v.
  - The clamp flag is the OR of the per-lane clamp bits.
- Counter:
  - sat_count increments on each res handshake whose clamp flag is set.
  - It sticks at all-ones and does not wrap.
  - sat_clear takes priority over a same-cycle increment.

Optional Feature:
- Macro: SATURATE_SHIFT_ROUND_EN.
- Defined: round half up. For e>0, add 2^(e-1) before shifting, computed in ARGW+1 bits so the addition cannot overflow. e=ARGW then always yields 0. Saturation is applied after rounding.
- Undefined: truncation (floor), with no adder in S1.

Decomposition:
- saturate_pkg contains:
  - function sat_clamp(value, RESW) returning the result and a clamp bit.
  - function ashr_round(value, e).
  - localparams for the max/min RESW constants.
- Sub-module saturate_lane: combinational shift, optional round and clamp for one lane. It is instantiated CHAN times via generate; the registers stay in saturate_shift.

Test Plan (ARGW=24, RESW=16 unless stated):
- Passthrough, shift=0: 0x0000ff→0x00ff, 0xffff00→0xff00, 0x7fffff→0x7fff, 0x800000→0x8000. sat_count=2 afterwards.
- Shift with the macro undefined, shift=4: 0x000018→0x0001 and 0xffffe8→0xfffe. With the macro defined: 0x000018→0x0002, 0xffffe8→0xffff. In both builds shift=24 (=ARGW): 0x123456→0x0000. With the macro undefined, shift=31: 0x800000→0xffff.
- CHAN=4: lanes {0x7fffff, 0x000100, 0x800000, 0xfffffe}, shift=8 → {0x7fff, 0x0001, 0x8000, 0xffff}. The beat is not clamped, so sat_count is unchanged.
- Backpressure: stream 16 beats with res_ready toggling pseudo-randomly and arg_valid gapped. The output sequence must match the model exactly, res_data must hold while stalled, and streaming with res_ready=1 must reach 1 beat/cycle with 2-cycle latency.
- Counter: force CNTW=4, send 20 clamped beats → sat_count=0xf held. Assert sat_clear in the same cycle as a clamped handshake → sat_count=0.
- Reset mid-stream: assert rst with both stages full → next cycle res_valid=0, sat_count=0, arg_ready=1. Re-run the passthrough scenario and get identical results.

Source files
------------

// File: rtl/saturate_pkg.sv
// saturate_pkg: shared types, bounds and arithmetic helpers for the saturating requantiser.
// Latency: none (functions only; evaluated inside combinational lane logic).
// Backpressure: n/a. Rounding (round half up) is enabled by SATURATE_SHIFT_ROUND_EN.
package saturate_pkg;

  // Working width for lane arithmetic; wide enough for any practical ARGW + 1.
  localparam int WIDEW = 64;
  typedef logic signed [WIDEW-1:0] wide_t;

  // Clamped value plus a flag saying whether clamping happened.
  typedef struct packed {
    wide_t value;
    logic  clamp;
  } sat_t;

  // Bounds for the default 16-bit result width.
  localparam int    RESW_DEF    = 16;
  localparam wide_t RES_MAX_DEF = (wide_t'(1) <<< (RESW_DEF - 1)) - wide_t'(1);
  localparam wide_t RES_MIN_DEF = -(wide_t'(1) <<< (RESW_DEF - 1));

  function automatic wide_t res_max(input int resw);
    return (wide_t'(1) <<< (resw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t res_min(input int resw);
    return -(wide_t'(1) <<< (resw - 1));
  endfunction

  // Clamp a signed value into resw-bit two's complement range.
  function automatic sat_t sat_clamp(input wide_t value, input int resw);
    sat_t r;
    r.clamp = 1'b1;
    if (value > res_max(resw)) begin
      r.value = res_max(resw);
    end else if (value < res_min(resw)) begin
      r.value = res_min(resw);
    end else begin
      r.value = value;
      r.clamp = 1'b0;
    end
    return r;
  endfunction

  // Arithmetic right shift by e; with rounding the half-LSB bias is added first.
  // The working width is far larger than ARGW + 1, so the bias cannot overflow.
  function automatic wide_t ashr_round(input wide_t value, input int e);
    wide_t v;
    v = value;
`ifdef SATURATE_SHIFT_ROUND_EN
    if (e > 0) begin
      v = v + (wide_t'(1) <<< (e - 1));
    end
`endif
    return v >>> e;
  endfunction

endpackage

// File: rtl/saturate_lane.sv
// saturate_lane: combinational shift (optionally rounded) and clamp for one lane.
// Latency: 0; the shift and clamp halves sit on opposite sides of the S1 register in the top.
// Backpressure: none; the parent pipeline owns all state and handshakes.
module saturate_lane
  import saturate_pkg::*;
#(
  parameter int ARGW   = 24,
  parameter int RESW   = 16,
  parameter int SHIFTW = 5
) (
  input  logic signed [ARGW-1:0]   arg,
  input  logic        [SHIFTW-1:0] shift,
  output logic signed [ARGW:0]     shifted,
  input  logic signed [ARGW:0]     held,
  output logic        [RESW-1:0]   res,
  output logic                     clamp
);

  // Shift half: limit the shift to ARGW, then shift (rounding when enabled).
  always_comb begin
    int    e;
    wide_t w;
    e       = (int'(shift) > ARGW) ? ARGW : int'(shift);
    w       = ashr_round(wide_t'(arg), e);
    shifted = w[ARGW:0];
  end

  // Clamp half: saturate the registered shifted value to RESW bits.
  always_comb begin
    sat_t s;
    s     = sat_clamp(wide_t'(held), RESW);
    res   = s.value[RESW-1:0];
    clamp = s.clamp;
  end

endmodule

// File: rtl/saturate_shift.sv
// saturate_shift: per-lane arithmetic right shift then saturation ARGW->RESW, with a sticky clamp counter.
// Latency: 2 cycles arg handshake to res_valid; 1 beat/cycle. Rounding via SATURATE_SHIFT_ROUND_EN.
// Backpressure: res_ready stalls S2, which stalls S1; arg_ready = !s1_valid | s2_load (comb from res_ready).
module saturate_shift
  import saturate_pkg::*;
#(
  parameter int ARGW   = 24,
  parameter int RESW   = 16,   // must not exceed ARGW
  parameter int CHAN   = 1,
  parameter int SHIFTW = 5,
  parameter int CNTW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SHIFTW-1:0]    shift,
  input  logic                 arg_valid,
  input  logic [CHAN*ARGW-1:0] arg_data,
  output logic                 arg_ready,
  output logic                 res_valid,
  output logic [CHAN*RESW-1:0] res_data,
  input  logic                 res_ready,
  input  logic                 sat_clear,
  output logic [CNTW-1:0]      sat_count
);

  logic                       s1_valid;
  logic [CHAN-1:0][ARGW:0]    s1_data;
  logic [CHAN-1:0][ARGW:0]    s1_next;
  logic [CHAN-1:0][RESW-1:0]  s2_next;
  logic [CHAN-1:0]            lane_clamp;
  logic                       s2_clamp;
  logic                       s2_load;

  assign s2_load   = !res_valid || res_ready;
  assign arg_ready = !s1_valid || s2_load;

  for (genvar i = 0; i < CHAN; i++) begin : g_lane
    saturate_lane #(
      .ARGW   (ARGW),
      .RESW   (RESW),
      .SHIFTW (SHIFTW)
    ) u_lane (
      .arg     (arg_data[i*ARGW +: ARGW]),
      .shift   (shift),
      .shifted (s1_next[i]),
      .held    (s1_data[i]),
      .res     (s2_next[i]),
      .clamp   (lane_clamp[i])
    );
  end

  // Two-stage pipeline: S1 holds shifted lanes, S2 holds saturated lanes and the beat clamp flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      s2_clamp  <= 1'b0;
    end else begin
      if (arg_ready) begin
        s1_valid <= arg_valid;
        if (arg_valid) begin
          s1_data <= s1_next;
        end
      end
      if (s2_load) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_data <= s2_next;
          s2_clamp <= |lane_clamp;
        end
      end
    end
  end

  // Sticky count of delivered beats that clamped; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clear) begin
      sat_count <= '0;
    end else if (res_valid && res_ready && s2_clamp && (sat_count != {CNTW{1'b1}})) begin
      sat_count <= sat_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_saturate_shift.sv
module tb_saturate_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Main instance: CHAN=1, CNTW=16
  logic [4:0]  shift = '0;
  logic        arg_valid = 1'b0;
  logic [23:0] arg_data = '0;
  logic        arg_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b1;
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;

  // Four-lane instance
  logic [4:0]  d4_shift = '0;
  logic        d4_arg_valid = 1'b0;
  logic [95:0] d4_arg_data = '0;
  logic        d4_arg_ready;
  logic        d4_res_valid;
  logic [63:0] d4_res_data;
  logic        d4_res_ready = 1'b1;
  logic        d4_sat_clear = 1'b0;
  logic [15:0] d4_sat_count;

  // Narrow-counter instance: CNTW=4
  logic [4:0]  c_shift = '0;
  logic        c_arg_valid = 1'b0;
  logic [23:0] c_arg_data = '0;
  logic        c_arg_ready;
  logic        c_res_valid;
  logic [15:0] c_res_data;
  logic        c_res_ready = 1'b1;
  logic        c_sat_clear = 1'b0;
  logic [3:0]  c_sat_count;

  saturate_shift #(.ARGW(24), .RESW(16), .CHAN(1), .SHIFTW(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .shift(shift), .arg_valid(arg_valid), .arg_data(arg_data),
    .arg_ready(arg_ready), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .sat_clear(sat_clear), .sat_count(sat_count));

  saturate_shift #(.ARGW(24), .RESW(16), .CHAN(4), .SHIFTW(5), .CNTW(16)) dut4 (
    .clk(clk), .rst(rst), .shift(d4_shift), .arg_valid(d4_arg_valid), .arg_data(d4_arg_data),
    .arg_ready(d4_arg_ready), .res_valid(d4_res_valid), .res_data(d4_res_data), .res_ready(d4_res_ready),
    .sat_clear(d4_sat_clear), .sat_count(d4_sat_count));

  saturate_shift #(.ARGW(24), .RESW(16), .CHAN(1), .SHIFTW(5), .CNTW(4)) dutc (
    .clk(clk), .rst(rst), .shift(c_shift), .arg_valid(c_arg_valid), .arg_data(c_arg_data),
    .arg_ready(c_arg_ready), .res_valid(c_res_valid), .res_data(c_res_data), .res_ready(c_res_ready),
    .sat_clear(c_sat_clear), .sat_count(c_sat_count));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: floor(x / 2^e) (or round half up), then clamp to 16-bit signed.
  function automatic logic [16:0] model(input logic [23:0] a, input logic [4:0] sh);
    longint x, p, q;
    int e;
    logic [63:0] t;
    x = longint'($signed(a));
    e = (int'(sh) > 24) ? 24 : int'(sh);
    p = longint'(1) << e;
`ifdef SATURATE_SHIFT_ROUND_EN
    if (e > 0) x = x + p / 2;
`endif
    if (x >= 0) q = x / p;
    else        q = -((-x + p - 1) / p);
    if (q > 32767)  return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    t = q;
    return {1'b0, t[15:0]};
  endfunction

  typedef struct {
    logic [15:0] res;
    logic        clamp;
    bit          haslit;
    logic [15:0] lit;
    string       name;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  bit          started = 0;
  bit          lat_chk = 0;
  bit          bp = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_dat = '0;
  logic [15:0] m_cnt = '0;
  bit          cur_haslit = 0;
  logic [15:0] cur_lit = '0;
  string       cur_name = "";

  always @(posedge clk) cyc <= cyc + 1;

  // Random downstream stalls while bp is set.
  initial forever begin
    @(posedge clk); #1;
    if (bp) res_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: checks every output beat, hold-while-stalled and the counter on every cycle.
  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      logic [16:0] m;
      bit inc;
      inc = 0;
      if (prev_stall) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, prev_dat);
      end
      chk("sat_count", sat_count, m_cnt);
      if (rst) begin
        q.delete();
        m_cnt = '0;
        prev_stall = 0;
      end else begin
        if (res_valid && res_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_beat: got beat %0h with none outstanding", res_data);
          end else begin
            e = q.pop_front();
            chk("model_data", res_data, e.res);
            if (e.haslit) chk(e.name, res_data, e.lit);
            if (e.cyc >= 0) chk("latency", cyc - e.cyc, 2);
            inc = e.clamp;
          end
        end
        if (arg_valid && arg_ready) begin
          m = model(arg_data, shift);
          e.res = m[15:0];
          e.clamp = m[16];
          e.haslit = cur_haslit;
          e.lit = cur_lit;
          e.name = cur_name;
          e.cyc = lat_chk ? cyc : -1;
          q.push_back(e);
        end
        if (sat_clear) m_cnt = '0;
        else if (inc && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        prev_stall = res_valid && !res_ready;
        prev_dat = res_data;
      end
    end
  end

  task automatic send(input logic [23:0] d, input logic [4:0] s, input bit haslit,
                      input logic [15:0] lit, input string nm, input bit chk_rdy);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    arg_valid = 1'b1; arg_data = d; shift = s;
    cur_haslit = haslit; cur_lit = lit; cur_name = nm;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = arg_ready;
      if (chk_rdy && n == 0) chk("stream_ready", arg_ready, 1);
      @(posedge clk); #1;
      n++;
    end
    arg_valid = 1'b0;
    cur_haslit = 0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: arg_ready never 1, expected acceptance of %0h", d);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || res_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic run_pass();
    send(24'h0000ff, 5'd0, 1, 16'h00ff, "pass_ff", 0);
    send(24'hffff00, 5'd0, 1, 16'hff00, "pass_neg", 0);
    send(24'h7fffff, 5'd0, 1, 16'h7fff, "pass_max", 0);
    send(24'h800000, 5'd0, 1, 16'h8000, "pass_min", 0);
    drain();
    chk("pass_count", sat_count, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    started = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_arg_ready", arg_ready, 1);
    @(posedge clk); #1;

    run_pass();

    // Shift cases
`ifdef SATURATE_SHIFT_ROUND_EN
    send(24'h000018, 5'd4, 1, 16'h0002, "shr4_pos", 0);
    send(24'hffffe8, 5'd4, 1, 16'hffff, "shr4_neg", 0);
    send(24'h800000, 5'd31, 1, 16'h0000, "shr31_min", 0);
`else
    send(24'h000018, 5'd4, 1, 16'h0001, "shr4_pos", 0);
    send(24'hffffe8, 5'd4, 1, 16'hfffe, "shr4_neg", 0);
    send(24'h800000, 5'd31, 1, 16'hffff, "shr31_min", 0);
`endif
    send(24'h123456, 5'd24, 1, 16'h0000, "shr24", 0);
    drain();

    // Back-to-back stream with res_ready high: full rate, 2-cycle latency
    lat_chk = 1;
    for (int i = 0; i < 8; i++)
      send(24'(i * 24'h013579 + 24'h7f0000), 5'(i % 5), 0, '0, "", 1);
    lat_chk = 0;
    drain();

    // Randomised backpressure and gapped input
    bp = 1;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(24'($urandom), 5'($urandom_range(0, 31)), 0, '0, "", 0);
    end
    bp = 0;
    res_ready = 1'b1;
    drain();

    // Reset with both stages full
    res_ready = 1'b0;
    arg_valid = 1'b1; arg_data = 24'h7fffff; shift = 5'd0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("full_arg_ready", arg_ready, 0);
    @(posedge clk); #1;
    arg_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    chk("mid_rst_arg_ready", arg_ready, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    run_pass();

    // Four lanes, shift 8
    d4_shift = 5'd8;
    d4_arg_data = {24'hfffffe, 24'h800000, 24'h000100, 24'h7fffff};
    d4_arg_valid = 1'b1;
    @(posedge clk); #1;
    d4_arg_valid = 1'b0;
    @(negedge clk);
    chk("chan4_lat1_valid", d4_res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("chan4_valid", d4_res_valid, 1);
`ifdef SATURATE_SHIFT_ROUND_EN
    chk("chan4_data", d4_res_data, 64'h0000_8000_0001_7fff);
    @(posedge clk);
    @(negedge clk);
    chk("chan4_count", d4_sat_count, 1);
`else
    chk("chan4_data", d4_res_data, 64'hffff_8000_0001_7fff);
    @(posedge clk);
    @(negedge clk);
    chk("chan4_count", d4_sat_count, 0);
`endif
    @(posedge clk); #1;

    // Narrow counter: sticks at all-ones
    c_arg_data = 24'h7fffff;
    c_arg_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    c_arg_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("cnt_sticky", c_sat_count, 4'hf);

    // Clear in the same cycle as a clamped handshake
    c_res_ready = 1'b0;
    c_arg_valid = 1'b1;
    @(posedge clk); #1;
    c_arg_valid = 1'b0;
    n = 0;
    while (!c_res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_wait_valid", c_res_valid, 1);
    chk("clr_pre_count", c_sat_count, 4'hf);
    c_res_ready = 1'b1;
    c_sat_clear = 1'b1;
    @(posedge clk); #1;
    c_sat_clear = 1'b0;
    chk("clr_priority", c_sat_count, 0);
    chk("clr_beat_taken", c_res_valid, 0);
    c_arg_valid = 1'b1;
    @(posedge clk); #1;
    c_arg_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("cnt_after_clear", c_sat_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
